trail_board: RTL and testbench



---
 rtl/tron_pkg.sv | 34 +++
 rtl/board_ram.sv | 24 ++
 rtl/trail_board.sv | 160 ++++++++++++++++
 tb/tb_trail_board.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tron_pkg.sv
// Shared screen geometry, colour codes and sequencer states for the trail board.
// Latency: none (declarations and a pure address helper only).
// Backpressure: not applicable.
package tron_pkg;

  localparam int X_MAX = 160;
  localparam int Y_MAX = 120;
  localparam int XW    = 8;
  localparam int YW    = 7;
  localparam int AW    = 15;

  localparam logic [2:0] COL_BLACK  = 3'b000;
  localparam logic [2:0] COL_BORDER = 3'b111;
  localparam logic [2:0] COL_P1     = 3'b101;
  localparam logic [2:0] COL_P2     = 3'b011;
  localparam logic [2:0] COL_CRASH  = 3'b100;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    READ  = 2'd2,
    CHECK = 2'd3
  } state_t;

  // Row-major cell index y*160 + x, built from shifts so no multiplier is needed.
  function automatic logic [AW-1:0] cell_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    logic [AW-1:0] yy;
    logic [AW-1:0] xx;
    yy = {{(AW-YW){1'b0}}, y};
    xx = {{(AW-XW){1'b0}}, x};
    return (yy << 7) + (yy << 5) + xx;
  endfunction

endpackage

// File: rtl/board_ram.sv
// One occupancy bit per screen cell, single port, write-first-ignored (read returns old data).
// Latency: read data valid one clock after the address is presented.
// Backpressure: none; accepts an access every cycle.
module board_ram
  import tron_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic          wdata,
  output logic          rdata
);

  logic mem [0:X_MAX*Y_MAX-1];

  // Synchronous write and registered read; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/trail_board.sv
// Occupancy check for game moves plus pixel sequencer that wipes and repaints the screen.
// Latency: move accepted in cycle N reports result/plot in cycle N+2; sweep takes 19200 cycles.
// Backpressure: move_ready low outside IDLE, while a clear is pending, or when clear_req is high.
module trail_board
  import tron_pkg::*;
(
  input  logic          clk,
  input  logic          resetn,
  input  logic          clear_req,
  output logic          clear_busy,
  input  logic          move_valid,
  output logic          move_ready,
  input  logic [XW-1:0] move_x,
  input  logic [YW-1:0] move_y,
  input  logic          move_player,
  output logic          result_valid,
  output logic          result_hit,
  output logic          result_player,
  output logic          plot,
  output logic [XW-1:0] plot_x,
  output logic [YW-1:0] plot_y,
  output logic [2:0]    plot_colour
);

  state_t        state, state_nxt;
  logic [XW-1:0] cx, mx, px_q;
  logic [YW-1:0] cy, my, py_q;
  logic [2:0]    pc_q, chk_col;
  logic          mp, moor, pend, plot_q;
  logic          ram_we, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;
  logic          sweep_last, border, accept, hit, chk_plot;

  assign sweep_last = (cx == XW'(X_MAX-1)) && (cy == YW'(Y_MAX-1));
  assign border     = (cx == '0) || (cx == XW'(X_MAX-1)) || (cy == '0) || (cy == YW'(Y_MAX-1));
  assign move_ready = (state == IDLE) && !pend && !clear_req;
  assign accept     = move_valid && move_ready;
  assign hit        = moor || ram_rdata;
  assign chk_plot   = (state == CHECK) && !moor;
  assign chk_col    = ram_rdata ? COL_CRASH : (mp ? COL_P2 : COL_P1);

  // The CHECK-cycle result is combinational on the RAM read data; the sweep plot is
  // registered, and the pixel fields fall back to the last plotted values otherwise.
  assign clear_busy    = (state == CLEAR);
  assign result_valid  = (state == CHECK);
  assign result_hit    = (state == CHECK) && hit;
  assign result_player = (state == CHECK) && mp;
  assign plot          = plot_q || chk_plot;
  assign plot_x        = chk_plot ? mx : px_q;
  assign plot_y        = chk_plot ? my : py_q;
  assign plot_colour   = chk_plot ? chk_col : pc_q;

  board_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= CLEAR;
    else         state <= state_nxt;
  end

  // Next-state logic; a clear in IDLE beats a simultaneous move.
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (sweep_last) state_nxt = IDLE;
      IDLE:    if (clear_req) state_nxt = CLEAR;
               else if (accept) state_nxt = READ;
      READ:    state_nxt = CHECK;
      CHECK:   state_nxt = (pend || clear_req) ? CLEAR : IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  // RAM port steering; out-of-range moves park the address at 0 and never write.
  always_comb begin
    ram_we    = 1'b0;
    ram_wdata = 1'b0;
    ram_addr  = moor ? '0 : cell_addr(mx, my);
    case (state)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_wdata = border;
        ram_addr  = cell_addr(cx, cy);
      end
      CHECK: begin
        ram_we    = !hit;
        ram_wdata = 1'b1;
      end
      default: ;
    endcase
  end

  // Sweep counters: row-major walk while clearing, parked at (0,0) otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cx <= '0;
      cy <= '0;
    end else if (state == CLEAR) begin
      if (cx == XW'(X_MAX-1)) begin
        cx <= '0;
        cy <= (cy == YW'(Y_MAX-1)) ? '0 : cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end else begin
      cx <= '0;
      cy <= '0;
    end
  end

  // Capture the accepted move and flag out-of-range coordinates up front.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mx   <= '0;
      my   <= '0;
      mp   <= 1'b0;
      moor <= 1'b0;
    end else if (accept) begin
      mx   <= move_x;
      my   <= move_y;
      mp   <= move_player;
      moor <= (move_x >= XW'(X_MAX)) || (move_y >= YW'(Y_MAX));
    end
  end

  // Remember a clear that arrives while a move is in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) pend <= 1'b0;
    else         pend <= (state == READ) && (pend || clear_req);
  end

  // Pixel output registers: sweep plots are emitted a cycle after the cell write,
  // and every plot updates the held coordinates and colour.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      plot_q <= 1'b0;
      px_q   <= '0;
      py_q   <= '0;
      pc_q   <= COL_BLACK;
    end else begin
      plot_q <= (state == CLEAR);
      if (state == CLEAR) begin
        px_q <= cx;
        py_q <= cy;
        pc_q <= border ? COL_BORDER : COL_BLACK;
      end else if (chk_plot) begin
        px_q <= mx;
        py_q <= my;
        pc_q <= chk_col;
      end
    end
  end

endmodule

// File: tb/tb_trail_board.sv
// Self-checking bench for trail_board: table vectors, hand-written sequences, random moves.
// Latency: checks the N+2 result timing and the 19200-cycle sweep.
// Backpressure: every move waits (bounded) for move_ready before being counted as accepted.
module tb_trail_board;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       clear_req = 1'b0;
  logic       clear_busy;
  logic       move_valid = 1'b0;
  logic       move_ready;
  logic [7:0] move_x = 8'd0;
  logic [6:0] move_y = 7'd0;
  logic       move_player = 1'b0;
  logic       result_valid, result_hit, result_player;
  logic       plot;
  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic [2:0] plot_colour;

  int nvec = 0;
  int nerr = 0;

  bit         occ [0:159][0:119];
  logic [7:0] last_px;
  logic [6:0] last_py;
  logic [2:0] last_pc;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic       p;
    logic       eh;
    logic       ep;
    logic [2:0] ec;
  } vec_t;
  vec_t tbl [9];

  always #5 clk = ~clk;

  trail_board dut (
    .clk           (clk),
    .resetn        (resetn),
    .clear_req     (clear_req),
    .clear_busy    (clear_busy),
    .move_valid    (move_valid),
    .move_ready    (move_ready),
    .move_x        (move_x),
    .move_y        (move_y),
    .move_player   (move_player),
    .result_valid  (result_valid),
    .result_hit    (result_hit),
    .result_player (result_player),
    .plot          (plot),
    .plot_x        (plot_x),
    .plot_y        (plot_y),
    .plot_colour   (plot_colour)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  // Board model: the border is occupied, everything else free.
  function automatic void model_reset();
    for (int x = 0; x < 160; x++)
      for (int y = 0; y < 120; y++)
        occ[x][y] = (x == 0 || x == 159 || y == 0 || y == 119);
    last_px = 8'd159;
    last_py = 7'd119;
    last_pc = 3'b111;
  endfunction

  // Game rules: out of range is a hit with no pixel, occupied is a red crash, else claim the cell.
  function automatic void model_move(input logic [7:0] x, input logic [6:0] y, input logic p,
                                     output logic eh, output logic ep, output logic [2:0] ec);
    if (x >= 8'd160 || y >= 7'd120) begin
      eh = 1'b1; ep = 1'b0; ec = 3'b000;
    end else if (occ[x][y]) begin
      eh = 1'b1; ep = 1'b1; ec = 3'b100;
    end else begin
      eh = 1'b0; ep = 1'b1; ec = p ? 3'b011 : 3'b101;
      occ[x][y] = 1'b1;
    end
  endfunction

  // Entered at posedge+1 of an IDLE cycle; leaves at posedge+1 after the CHECK cycle.
  task automatic do_move(input string nm, input logic [7:0] x, input logic [6:0] y, input logic p,
                         input logic eh, input logic ep, input logic [2:0] ec);
    int w;
    w = 0;
    move_x = x; move_y = y; move_player = p; move_valid = 1'b1;
    samp();
    while (move_ready !== 1'b1 && w < 1000) begin
      next(); samp(); w++;
    end
    chk({nm, " accept"}, 32'(move_ready), 1);
    next();
    move_valid = 1'b0;
    samp();
    chk({nm, " early_result"}, 32'(result_valid), 0);
    next();
    samp();
    chk({nm, " result_valid"}, 32'(result_valid), 1);
    chk({nm, " hit"}, 32'(result_hit), 32'(eh));
    chk({nm, " player"}, 32'(result_player), 32'(p));
    chk({nm, " plot"}, 32'(plot), 32'(ep));
    if (ep) begin
      chk({nm, " plot_x"}, 32'(plot_x), 32'(x));
      chk({nm, " plot_y"}, 32'(plot_y), 32'(y));
      chk({nm, " colour"}, 32'(plot_colour), 32'(ec));
      last_px = x; last_py = y; last_pc = ec;
    end else begin
      chk({nm, " hold_x"}, 32'(plot_x), 32'(last_px));
      chk({nm, " hold_colour"}, 32'(plot_colour), 32'(last_pc));
    end
    next();
  endtask

  task automatic model_and_move(input string nm, input logic [7:0] x, input logic [6:0] y, input logic p);
    logic eh, ep;
    logic [2:0] ec;
    model_move(x, y, p, eh, ep, ec);
    do_move(nm, x, y, p, eh, ep, ec);
  endtask

  // Called having just sampled the first busy cycle; counts busy cycles and stops at the
  // negedge of the first idle cycle, which must carry the final sweep pixel.
  task automatic wait_sweep(input string nm);
    int n;
    n = 0;
    while (clear_busy === 1'b1 && n < 25000) begin
      n++; next(); samp();
    end
    chk({nm, " busy_cycles"}, 32'(n), 19200);
    chk({nm, " last_plot"}, 32'(plot), 1);
    chk({nm, " last_x"}, 32'(plot_x), 159);
    chk({nm, " last_y"}, 32'(plot_y), 119);
    chk({nm, " last_colour"}, 32'(plot_colour), 32'(3'b111));
    next();
    model_reset();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int sweep_err, ready_seen, busy_err;
    logic eh, ep;
    logic [2:0] ec;
    logic [7:0] rx;
    logic [6:0] ry;

    tbl[0] = '{8'd5,   7'd5,   1'b1, 1'b1, 1'b1, 3'b100};
    tbl[1] = '{8'd0,   7'd60,  1'b1, 1'b1, 1'b1, 3'b100};
    tbl[2] = '{8'd160, 7'd10,  1'b0, 1'b1, 1'b0, 3'b000};
    tbl[3] = '{8'd159, 7'd119, 1'b1, 1'b1, 1'b1, 3'b100};
    tbl[4] = '{8'd158, 7'd118, 1'b0, 1'b0, 1'b1, 3'b101};
    tbl[5] = '{8'd158, 7'd118, 1'b1, 1'b1, 1'b1, 3'b100};
    tbl[6] = '{8'd10,  7'd120, 1'b0, 1'b1, 1'b0, 3'b000};
    tbl[7] = '{8'd6,   7'd5,   1'b1, 1'b0, 1'b1, 3'b011};
    tbl[8] = '{8'd255, 7'd127, 1'b1, 1'b1, 1'b0, 3'b000};

    // Reset state, with a move already being offered.
    move_x = 8'd5; move_y = 7'd5; move_player = 1'b0; move_valid = 1'b1;
    samp();
    chk("reset clear_busy", 32'(clear_busy), 1);
    chk("reset move_ready", 32'(move_ready), 0);
    chk("reset result_valid", 32'(result_valid), 0);
    chk("reset result_hit", 32'(result_hit), 0);
    chk("reset result_player", 32'(result_player), 0);
    chk("reset plot", 32'(plot), 0);
    chk("reset plot_xyc", 32'({plot_x, plot_y, plot_colour}), 0);
    next();
    resetn = 1'b1;

    // Power-up sweep: cycle c shows cell c-1 of the row-major walk.
    sweep_err = 0; ready_seen = 0; busy_err = 0;
    for (int c = 0; c <= 19200; c++) begin
      samp();
      if (c == 0) chk("sweep first_cycle_plot", 32'(plot), 0);
      else begin
        int k, ex, ey;
        logic [2:0] ecol;
        k = c - 1; ex = k % 160; ey = k / 160;
        ecol = (ex == 0 || ex == 159 || ey == 0 || ey == 119) ? 3'b111 : 3'b000;
        if (plot !== 1'b1 || plot_x !== 8'(ex) || plot_y !== 7'(ey) || plot_colour !== ecol)
          sweep_err++;
        if (c == 1)   chk("sweep (0,0) colour", 32'({plot, plot_x, plot_y, plot_colour}), 32'({1'b1, 8'd0, 7'd0, 3'b111}));
        if (c == 162) chk("sweep (1,1) colour", 32'({plot, plot_x, plot_y, plot_colour}), 32'({1'b1, 8'd1, 7'd1, 3'b000}));
      end
      if (c < 19200) begin
        if (move_ready !== 1'b0) ready_seen++;
        if (clear_busy !== 1'b1) busy_err++;
        next();
      end
    end
    chk("sweep pixel_sequence_errors", 32'(sweep_err), 0);
    chk("sweep ready_while_busy", 32'(ready_seen), 0);
    chk("sweep busy_low_early", 32'(busy_err), 0);
    chk("sweep (159,119)", 32'({plot, plot_x, plot_y, plot_colour}), 32'({1'b1, 8'd159, 7'd119, 3'b111}));
    chk("sweep busy_fell", 32'(clear_busy), 0);
    chk("sweep first_ready", 32'(move_ready), 1);

    // The held move (5,5,P1) is accepted in this cycle; its result lands two cycles later.
    model_reset();
    next();
    move_valid = 1'b0;
    samp();
    chk("first_move early_result", 32'(result_valid), 0);
    next();
    samp();
    model_move(8'd5, 7'd5, 1'b0, eh, ep, ec);
    chk("first_move result", 32'({result_valid, result_hit, result_player}), 32'(3'b100));
    chk("first_move plot", 32'({plot, plot_x, plot_y, plot_colour}), 32'({1'b1, 8'd5, 7'd5, 3'b101}));
    last_px = 8'd5; last_py = 7'd5; last_pc = 3'b101;
    next();

    // Table vectors; the model is kept in step but expectations come from the table.
    for (int i = 0; i < 9; i++) begin
      model_move(tbl[i].x, tbl[i].y, tbl[i].p, eh, ep, ec);
      do_move($sformatf("tbl%0d", i), tbl[i].x, tbl[i].y, tbl[i].p, tbl[i].eh, tbl[i].ep, tbl[i].ec);
    end

    // clear_req and move_valid together in IDLE: clear wins, move is not taken.
    clear_req = 1'b1; move_valid = 1'b1;
    move_x = 8'd9; move_y = 7'd9; move_player = 1'b0;
    samp();
    chk("clr+move ready", 32'(move_ready), 0);
    next();
    clear_req = 1'b0; move_valid = 1'b0;
    samp();
    chk("clr+move busy_next_cycle", 32'(clear_busy), 1);
    chk("clr+move no_result", 32'(result_valid), 0);
    wait_sweep("clr+move");
    do_move("after_clear (5,5)", 8'd5, 7'd5, 1'b0, 1'b0, 1'b1, 3'b101);
    occ[5][5] = 1'b1;
    model_and_move("after_clear (9,9)", 8'd9, 7'd9, 1'b0);

    // clear_req one cycle after acceptance: move completes, then the sweep runs.
    move_x = 8'd20; move_y = 7'd20; move_player = 1'b1; move_valid = 1'b1;
    samp();
    chk("inflight accept", 32'(move_ready), 1);
    next();
    move_valid = 1'b0; clear_req = 1'b1;
    samp();
    chk("inflight read_no_result", 32'(result_valid), 0);
    next();
    clear_req = 1'b0;
    samp();
    chk("inflight result", 32'({result_valid, result_hit, result_player}), 32'(3'b101));
    chk("inflight plot", 32'({plot, plot_x, plot_y, plot_colour}), 32'({1'b1, 8'd20, 7'd20, 3'b011}));
    next();
    samp();
    chk("inflight busy", 32'(clear_busy), 1);
    chk("inflight ready", 32'(move_ready), 0);
    wait_sweep("inflight");

    // Random moves clustered near corners so collisions and out-of-range cases recur.
    for (int i = 0; i < 40; i++) begin
      rx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(150, 200)) : 8'($urandom_range(0, 8));
      ry = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(110, 127)) : 7'($urandom_range(0, 8));
      model_and_move($sformatf("rnd%0d", i), rx, ry, 1'($urandom_range(0, 1)));
    end

    // Reset during READ: no result, outputs return to reset values, sweep restarts at (0,0).
    move_x = 8'd30; move_y = 7'd30; move_player = 1'b0; move_valid = 1'b1;
    samp();
    chk("rst_read accept", 32'(move_ready), 1);
    next();
    move_valid = 1'b0;
    samp();
    chk("rst_read no_result", 32'(result_valid), 0);
    #1;
    resetn = 1'b0;
    #1;
    chk("rst_read outputs", 32'({result_valid, result_hit, result_player, plot, plot_x, plot_y, plot_colour}), 0);
    chk("rst_read busy", 32'({clear_busy, move_ready}), 32'(2'b10));
    next();
    samp();
    chk("rst_read held_no_result", 32'({result_valid, plot}), 0);
    resetn = 1'b1;
    next();
    samp();
    chk("rst_read restart (0,0)", 32'({result_valid, plot, plot_x, plot_y, plot_colour}), 32'({1'b0, 1'b1, 8'd0, 7'd0, 3'b111}));
    next();
    samp();
    chk("rst_read restart (1,0)", 32'({plot, plot_x, plot_y, plot_colour}), 32'({1'b1, 8'd1, 7'd0, 3'b111}));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
